// File: rtl/shift_seq_ctrl.sv
// ----------------------------------------------------------------------------
// shift_seq_ctrl
//
// Command sequencer for an 8-bit multi-mode shift register. A command is taken
// on a cmd_valid/cmd_ready handshake and expands into an optional parallel load
// followed by cmd_count repetitions of a shift op, or a single clear/load. The
// register value after the command is returned on the rsp_valid/rsp_ready
// channel. The register has no idle code, so "hold" is expressed as a load of
// its own output (sr_ctrl=001, sr_data_in=sr_data_out).
//
// Optional build macro: SHIFT_SEQ_ABORT_EN
//   Adds input abort and output rsp_aborted. An abort in LOAD or SHIFT holds
//   the register that cycle and completes the command early with the partial
//   value, flagged on rsp_aborted.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cmd_valid/ready   command handshake
//   cmd_op            000 clr, 001 load, 010 lsr, 011 lsl, 100 asr,
//                     101 serial-in-left, 110 ror, 111 rol
//   cmd_load          shift ops: parallel-load cmd_data before shifting
//   cmd_data          parallel value for load / clear-load
//   cmd_ser           serial source for op 101, consumed MSB-first
//   cmd_count         number of shift cycles (shift ops only)
//   rsp_valid/ready   response handshake
//   rsp_data          register value after the command
//   sr_ctrl           to shift register ctrl
//   sr_data_in        to shift register data_in
//   sr_serial_in      to shift register serial_in
//   sr_data_out       from shift register data_out
// ----------------------------------------------------------------------------
module shift_seq_ctrl #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic             cmd_load,
   input  logic [7:0]       cmd_data,
   input  logic [7:0]       cmd_ser,
   input  logic [CNT_W-1:0] cmd_count,
`ifdef SHIFT_SEQ_ABORT_EN
   input  logic             abort,
   output logic             rsp_aborted,
`endif
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [7:0]       rsp_data,
   output logic [2:0]       sr_ctrl,
   output logic [7:0]       sr_data_in,
   output logic             sr_serial_in,
   input  logic [7:0]       sr_data_out
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [2:0] OP_LOAD   = 3'b001;
   localparam logic [2:0] OP_SERIAL = 3'b101;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [2:0]       r_op;
   logic [7:0]       r_data;
   logic [7:0]       r_ser;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_idx;
   logic             w_accept;
   logic             w_is_shift;
   logic             w_cmd_is_shift;
   logic             w_abort;

   assign cmd_ready      = (~rst) & (r_state == S_IDLE);
   assign w_accept       = cmd_valid & cmd_ready;
   // ops 000 and 001 are the only non-shift encodings
   assign w_is_shift     = (r_op[2:1] != 2'b00);
   assign w_cmd_is_shift = (cmd_op[2:1] != 2'b00);

   assign rsp_valid = (~rst) & (r_state == S_DONE);
   assign rsp_data  = sr_data_out;

`ifdef SHIFT_SEQ_ABORT_EN
   logic r_aborted;

   assign w_abort     = abort & ((r_state == S_LOAD) | (r_state == S_SHIFT));
   assign rsp_aborted = rsp_valid & r_aborted;

   // Abort flag: cleared by a new command, set when a command is cut short
   always_ff @(posedge clk) begin
      if (rst) begin
         r_aborted <= 1'b0;
      end else if (w_accept) begin
         r_aborted <= 1'b0;
      end else if (w_abort) begin
         r_aborted <= 1'b1;
      end else begin
         r_aborted <= r_aborted;
      end
   end
`else
   assign w_abort = 1'b0;
`endif

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (!w_cmd_is_shift || cmd_load) begin
                  w_state_nxt = S_LOAD;
               end else if (cmd_count != CNT_ZERO) begin
                  w_state_nxt = S_SHIFT;
               end else begin
                  w_state_nxt = S_DONE;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_LOAD: begin
            if (w_abort) begin
               w_state_nxt = S_DONE;
            end else if (w_is_shift && (r_cnt != CNT_ZERO)) begin
               w_state_nxt = S_SHIFT;
            end else begin
               w_state_nxt = S_DONE;
            end
         end
         S_SHIFT: begin
            // r_cnt holds the shifts still to do, including this one
            if (w_abort || (r_cnt == CNT_ONE)) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_SHIFT;
            end
         end
         S_DONE: begin
            if (rsp_ready) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_DONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State, command latch and shift counters
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_op    <= 3'b000;
         r_data  <= 8'h00;
         r_ser   <= 8'h00;
         r_cnt   <= CNT_ZERO;
         r_idx   <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op   <= cmd_op;
                  r_data <= cmd_data;
                  r_ser  <= cmd_ser;
                  r_cnt  <= cmd_count;
                  r_idx  <= 3'd0;
               end
            end
            S_SHIFT: begin
               if (!w_abort) begin
                  r_cnt <= r_cnt - CNT_ONE;
                  // 3-bit index wraps naturally for serial counts above 8
                  r_idx <= r_idx + 3'd1;
               end
            end
            default: begin
               r_cnt <= r_cnt;
            end
         endcase
      end
   end

   // Shift register drive: hold unless loading or shifting
   always_comb begin
      sr_ctrl      = OP_LOAD;
      sr_data_in   = sr_data_out;
      sr_serial_in = 1'b0;
      if (rst || w_abort) begin
         sr_ctrl    = OP_LOAD;
         sr_data_in = sr_data_out;
      end else begin
         case (r_state)
            S_LOAD: begin
               // shift ops pre-load with a plain load; clr/load use their own code
               if (w_is_shift) begin
                  sr_ctrl = OP_LOAD;
               end else begin
                  sr_ctrl = r_op;
               end
               sr_data_in = r_data;
            end
            S_SHIFT: begin
               sr_ctrl = r_op;
               if (r_op == OP_SERIAL) begin
                  sr_serial_in = r_ser[3'd7 - r_idx];
               end else begin
                  sr_serial_in = 1'b0;
               end
            end
            default: begin
               sr_ctrl    = OP_LOAD;
               sr_data_in = sr_data_out;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [2:0] cmd_op = 3'd0;
   logic       cmd_load = 1'b0;
   logic [7:0] cmd_data = 8'h00;
   logic [7:0] cmd_ser = 8'h00;
   logic [3:0] cmd_count = 4'd0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b1;
   logic [7:0] rsp_data;
   logic [2:0] sr_ctrl;
   logic [7:0] sr_data_in;
   logic       sr_serial_in;
   logic [7:0] sr_q = 8'h00;
`ifdef SHIFT_SEQ_ABORT_EN
   logic       abort = 1'b0;
   logic       rsp_aborted;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   shift_seq_ctrl #(.CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_load(cmd_load), .cmd_data(cmd_data), .cmd_ser(cmd_ser),
      .cmd_count(cmd_count),
`ifdef SHIFT_SEQ_ABORT_EN
      .abort(abort), .rsp_aborted(rsp_aborted),
`endif
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .sr_ctrl(sr_ctrl), .sr_data_in(sr_data_in), .sr_serial_in(sr_serial_in),
      .sr_data_out(sr_q)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // The shift register peripheral the sequencer drives
   always @(posedge clk) begin
      case (sr_ctrl)
         3'b000:  sr_q <= 8'h00;
         3'b001:  sr_q <= sr_data_in;
         3'b010:  sr_q <= {1'b0, sr_q[7:1]};
         3'b011:  sr_q <= {sr_q[6:0], 1'b0};
         3'b100:  sr_q <= {sr_q[7], sr_q[7:1]};
         3'b101:  sr_q <= {sr_q[6:0], sr_serial_in};
         3'b110:  sr_q <= {sr_q[0], sr_q[7:1]};
         default: sr_q <= {sr_q[6:0], sr_q[7]};
      endcase
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Command-level result of applying an op count times to a start value
   function automatic logic [7:0] expect_result(input logic [2:0] op, input logic ld,
         input logic [7:0] data, input logic [7:0] ser, input int n, input logic [7:0] start);
      logic [7:0]  v;
      logic [15:0] w;
      int          r;
      v = ld ? data : start;
      r = n % 8;
      case (op)
         3'd0: return 8'h00;
         3'd1: return data;
         3'd2: return (n >= 8) ? 8'h00 : 8'(v >> n);
         3'd3: begin w = {8'h00, v} << n; return w[7:0]; end
         3'd4: return (n >= 8) ? {8{v[7]}} : 8'($signed(v) >>> n);
         3'd5: begin
            for (int k = 0; k < n; k++) v = {v[6:0], ser[7 - (k % 8)]};
            return v;
         end
         3'd6: begin w = {v, v} >> r; return w[7:0]; end
         default: begin w = {v, v} << r; return w[15:8]; end
      endcase
   endfunction

   // Reference state for the running command
   bit         m_busy = 1'b0;
   int         m_acc, m_k, m_cnt;
   logic [2:0] m_op;
   logic       m_ld;
   logic [7:0] m_data, m_ser, m_exp;

   // Per-cycle comparison of every DUT output against the reference
   always @(negedge clk) begin
      int d, k;
      if (rst) begin
         chk("rst_cmd_ready", cmd_ready, 0);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_hold_ctrl", sr_ctrl, 3'b001);
         chk("rst_hold_data", sr_data_in, sr_q);
         m_busy = 1'b0;
      end else if (!m_busy) begin
         chk("idle_cmd_ready", cmd_ready, 1);
         chk("idle_rsp_valid", rsp_valid, 0);
         chk("idle_hold_ctrl", sr_ctrl, 3'b001);
         chk("idle_hold_data", sr_data_in, sr_q);
         chk("idle_serial", sr_serial_in, 0);
         if (cmd_valid) begin
            m_busy = 1'b1;
            m_acc  = cyc;
            m_op   = cmd_op;
            m_ld   = cmd_load;
            m_data = cmd_data;
            m_ser  = cmd_ser;
            m_cnt  = int'(cmd_count);
            m_k    = (cmd_op < 3'd2) ? 1 : int'(cmd_load) + int'(cmd_count);
            m_exp  = expect_result(cmd_op, cmd_load, cmd_data, cmd_ser,
                                   (cmd_op < 3'd2) ? 0 : int'(cmd_count), sr_q);
         end
      end else begin
         d = cyc - m_acc;
         chk("busy_cmd_ready", cmd_ready, 0);
         if (d <= m_k) begin
            chk("work_rsp_valid", rsp_valid, 0);
            if (m_op < 3'd2) begin
               chk("ld_ctrl", sr_ctrl, m_op);
               chk("ld_data", sr_data_in, m_data);
            end else if (m_ld && d == 1) begin
               chk("preload_ctrl", sr_ctrl, 3'b001);
               chk("preload_data", sr_data_in, m_data);
               chk("preload_serial", sr_serial_in, 0);
            end else begin
               k = d - 1 - int'(m_ld);
               chk("shift_ctrl", sr_ctrl, m_op);
               chk("shift_serial", sr_serial_in,
                   (m_op == 3'd5) ? 32'((m_ser >> (7 - (k % 8))) & 8'h01) : 32'd0);
            end
         end else begin
            chk("done_rsp_valid", rsp_valid, 1);
            chk("done_rsp_data", rsp_data, m_exp);
            chk("done_hold_ctrl", sr_ctrl, 3'b001);
            chk("done_hold_data", sr_data_in, sr_q);
            if (rsp_ready) m_busy = 1'b0;
         end
      end
   end

   // Drive one command; pin its response value and latency to literals
   task automatic run_cmd(input string nm, input logic [2:0] op, input logic ld,
         input logic [7:0] data, input logic [7:0] ser, input logic [3:0] cnt,
         input logic [7:0] exp_data, input int exp_lat, input int bp);
      int acc = 0;
      bit got = 1'b0;
      @(posedge clk); #1;
      cmd_op = op; cmd_load = ld; cmd_data = data; cmd_ser = ser; cmd_count = cnt;
      cmd_valid = 1'b1;
      rsp_ready = (bp == 0);
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (cmd_ready) begin got = 1'b1; acc = cyc; end
      end
      if (!got) chk({nm, "_accept_timeout"}, 0, 1);
      @(posedge clk); #1;
      // inputs are sampled only at accept: scramble them afterwards
      cmd_valid = 1'b0; cmd_data = ~data; cmd_ser = ~ser; cmd_count = ~cnt; cmd_op = ~op;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (rsp_valid) got = 1'b1;
      end
      if (!got) chk({nm, "_rsp_timeout"}, 0, 1);
      chk({nm, "_latency"}, cyc - acc, exp_lat);
      chk({nm, "_data"}, rsp_data, exp_data);
      if (bp > 0) begin
         for (int j = 1; j < bp; j++) begin
            @(posedge clk); #1;
            cmd_valid = (j < 3);   // offered while busy: must be ignored
            @(negedge clk);
            chk({nm, "_bp_data"}, rsp_data, exp_data);
            chk({nm, "_bp_ready"}, cmd_ready, 0);
         end
         @(posedge clk); #1;
         cmd_valid = 1'b0;
         rsp_ready = 1'b1;
         @(negedge clk);
         @(negedge clk);
         chk({nm, "_bp_idle"}, cmd_ready, 1);
      end
   endtask

   initial begin
      int acc;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_cmd_ready", cmd_ready, 1);
      chk("reset_rsp_valid", rsp_valid, 0);

      run_cmd("ror",     3'd6, 1'b1, 8'h81, 8'h00, 4'd1,  8'hC0, 3,  0);
      run_cmd("asr",     3'd4, 1'b1, 8'h80, 8'h00, 4'd3,  8'hF0, 5,  0);
      run_cmd("serial",  3'd5, 1'b1, 8'h00, 8'hA5, 4'd8,  8'hA5, 10, 0);
      run_cmd("rol_z",   3'd7, 1'b1, 8'h3C, 8'h00, 4'd0,  8'h3C, 2,  0);
      run_cmd("rol_w",   3'd7, 1'b0, 8'h00, 8'h00, 4'd9,  8'h78, 10, 0);
      run_cmd("load_bp", 3'd1, 1'b0, 8'h5A, 8'h00, 4'd3,  8'h5A, 2,  5);
      run_cmd("clr",     3'd0, 1'b0, 8'hFF, 8'h00, 4'd5,  8'h00, 2,  0);
      run_cmd("lsl",     3'd3, 1'b1, 8'h81, 8'h00, 4'd2,  8'h04, 4,  0);
      run_cmd("lsr",     3'd2, 1'b0, 8'h00, 8'h00, 4'd1,  8'h02, 2,  0);
      run_cmd("lsr_z",   3'd2, 1'b0, 8'h00, 8'h00, 4'd0,  8'h02, 1,  0);
      run_cmd("ser_w",   3'd5, 1'b1, 8'hFF, 8'h3C, 4'd10, 8'hF0, 12, 0);

      // Reset in the 4th SHIFT cycle of a long lsr
      @(posedge clk); #1;
      cmd_op = 3'd2; cmd_load = 1'b1; cmd_data = 8'hFF; cmd_count = 4'd10; cmd_valid = 1'b1;
      @(negedge clk);
      chk("rstmid_accept", cmd_ready, 1);
      acc = cyc;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rstmid_cycle", cyc - acc, 5);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rstmid_ready", cmd_ready, 1);
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         chk("rstmid_no_rsp", rsp_valid, 0);
      end

      run_cmd("reload",  3'd1, 1'b0, 8'h96, 8'h00, 4'd0,  8'h96, 2,  0);
      run_cmd("ror12",   3'd6, 1'b0, 8'h00, 8'h00, 4'd12, 8'h69, 13, 0);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Command sequencer for the 8-bit multi-mode shift register (8-bit, 3-bit op control, 8 modes). It accepts one command per valid/ready handshake. Each command is an optional parallel load followed by N repetitions of a shift op, or a single clear or load. It then returns the final register value on a valid/ready response channel. The block drives the register's ctrl, data_in and serial_in inputs every cycle and observes its data_out.

Parameters:
CNT_W, 4, width of cmd_count; max shifts per command = 2^CNT_W-1

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when cmd_valid&cmd_ready
cmd_op  input  3  register op encoding: 000 clr, 001 load, 010 lsr, 011 lsl, 100 asr, 101 serial-in-left, 110 ror, 111 rol
cmd_load  input  1  shift ops only: parallel-load cmd_data before shifting
cmd_data  input  8  parallel value for load/clear-load
cmd_ser  input  8  serial source for op 101, consumed MSB-first
cmd_count  input  CNT_W  number of shift cycles (shift ops only)
rsp_valid  output  1  result available
rsp_ready  input  1  result consumed when rsp_valid&rsp_ready
rsp_data  output  8  register value after command
sr_ctrl  output  3  to shift register ctrl
sr_data_in  output  8  to shift register data_in
sr_serial_in  output  1  to shift register serial_in
sr_data_out  input  8  from shift register data_out

Behaviour:
- Hold encoding: the register has no idle code. "Hold" = sr_ctrl=001, sr_data_in=sr_data_out. Hold is driven in IDLE and DONE, and during rst.
- States: IDLE, LOAD, SHIFT, DONE. Reset → IDLE, rsp_valid=0, internal counters 0. cmd_ready=0 while rst high.
- IDLE: cmd_ready=1. On accept, latch op, data, ser, count, load.
  - op 000/001 → LOAD (drives the cmd op with cmd_data, for 1 cycle).
  - shift op with cmd_load=1 → LOAD (ctrl=001, data_in=latched data).
  - shift op, load=0, count>0 → SHIFT.
  - shift op, load=0, count=0 → DONE.
- LOAD: 1 cycle. Then → SHIFT if shift op and count>0, else → DONE.
- SHIFT: sr_ctrl = latched op, for exactly count cycles (down-counter). On the last cycle → DONE.
- Serial source: for op 101, on shift k (0-based), sr_serial_in = ser[7-(k mod 8)]. Otherwise sr_serial_in=0.
- DONE: rsp_valid=1, rsp_data=sr_data_out (stable while held). On rsp_ready → IDLE. cmd_ready=0 in DONE, so the earliest next accept is the cycle after the response handshake.
- Latency: let the acceptance cycle be cycle 0. K = 1 for clr/load, K = cmd_load + cmd_count for shift ops. rsp_valid first high in cycle K+1.
- Counts >8 wrap naturally: rotations are modular, and serial index wraps mod 8.
- cmd_valid with cmd_ready=0 is ignored and not queued. cmd_* are sampled only at accept and may change afterward.
- rst in any state: next cycle IDLE, rsp_valid=0, in-flight command discarded, no response.

Optional Feature:
SHIFT_SEQ_ABORT_EN: adds input port abort (1 bit).
- With the macro: abort=1 in LOAD or SHIFT → hold driven that cycle, next state DONE. The response carries the partially shifted value and is flagged on an added output rsp_aborted (1 bit, valid with rsp_valid). abort is ignored in IDLE/DONE.
- Without the macro: neither port exists; every command runs to completion.

Test Plan:
- Rotate right: op=110, load=1, data=0x81, count=1 → rsp_valid cycle 3, rsp_data=0xC0.
- Arithmetic right: op=100, load=1, data=0x80, count=3 → rsp_data=0xF0, rsp_valid cycle 5.
- Serial in: op=101, load=1, data=0x00, ser=0xA5, count=8 → rsp_data=0xA5, rsp_valid cycle 10.
- Zero count and wrap: op=111, load=1, data=0x3C, count=0 → 0x3C in cycle 2. Then op=111, load=0, count=9 on prior 0x3C → 0x78.
- Backpressure: rsp_ready low 5 cycles in DONE → rsp_data constant, sr_ctrl=001 with data_in=data_out each cycle, cmd_ready=0. rsp_ready=1 → IDLE next cycle.
- Reset mid-SHIFT: op=010, count=10, rst pulsed in the 4th SHIFT cycle → next cycle IDLE, rsp_valid never asserts, cmd_ready=1 after rst low.
